// File: rtl/parking_pkg.sv
// Shared types and BCD helpers for the parking gate occupancy counter.
package parking_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    IDLE,
    ENT1,
    ENT2,
    ENT3,
    EXT1,
    EXT2,
    EXT3,
    WAIT_CLR
  } gate_state_t;

  localparam int MAX_BCD_OCCUPANCY = 99;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  function automatic bcd_pair_t bcd_inc(input bcd_pair_t v);
    bcd_pair_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_pair_t bcd_dec(input bcd_pair_t v);
    bcd_pair_t r;
    r = v;
    if (v.ones == 4'd0) begin
      r.ones = 4'd9;
      r.tens = v.tens - 4'd1;
    end else begin
      r.ones = v.ones - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce filter.
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_in,
  output logic sensor_deb
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sensor_in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle agreeing with the accepted level restarts the stability count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign sensor_deb = deb_q;

endmodule

// File: rtl/parking_occupancy_counter.sv
// Gate beam sequencer classifying entries/exits and keeping a BCD occupancy count.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY        = 25,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [3:0] tens_digit,
  output logic [3:0] ones_digit,
  output logic       full,
  output logic       empty,
  output logic       entry_pulse,
  output logic       exit_pulse,
  output logic       reject_pulse
);

  localparam bcd_t CAP_TENS = bcd_t'(CAPACITY / 10);
  localparam bcd_t CAP_ONES = bcd_t'(CAPACITY % 10);

  logic        a_deb, b_deb;
  logic [1:0]  ab;
  gate_state_t state_q, state_d;
  logic        done_entry, done_exit;
  bcd_pair_t   occ_q, occ_d;
  logic        full_q, full_d, empty_q, empty_d;
  logic        entry_q, entry_d, exit_q, exit_d, reject_q, reject_d;
  logic        at_cap, at_zero;

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_in  (sensor_a),
    .sensor_deb (a_deb)
  );

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_in  (sensor_b),
    .sensor_deb (b_deb)
  );

  assign ab = {a_deb, b_deb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Jumps of both beams at once are treated as noise: park in WAIT_CLR until clear.
  always_comb begin
    state_d    = state_q;
    done_entry = 1'b0;
    done_exit  = 1'b0;
    case (state_q)
      IDLE: begin
        case (ab)
          2'b10:   state_d = ENT1;
          2'b01:   state_d = EXT1;
          2'b11:   state_d = WAIT_CLR;
          default: state_d = IDLE;
        endcase
      end
      ENT1: begin
        case (ab)
          2'b11:   state_d = ENT2;
          2'b00:   state_d = IDLE;
          2'b01:   state_d = WAIT_CLR;
          default: state_d = ENT1;
        endcase
      end
      ENT2: begin
        case (ab)
          2'b01:   state_d = ENT3;
          2'b10:   state_d = ENT1;
          2'b00:   state_d = IDLE;
          default: state_d = ENT2;
        endcase
      end
      ENT3: begin
        case (ab)
          2'b00: begin
            state_d    = IDLE;
            done_entry = 1'b1;
          end
          2'b11:   state_d = ENT2;
          2'b10:   state_d = WAIT_CLR;
          default: state_d = ENT3;
        endcase
      end
      EXT1: begin
        case (ab)
          2'b11:   state_d = EXT2;
          2'b00:   state_d = IDLE;
          2'b10:   state_d = WAIT_CLR;
          default: state_d = EXT1;
        endcase
      end
      EXT2: begin
        case (ab)
          2'b10:   state_d = EXT3;
          2'b01:   state_d = EXT1;
          2'b00:   state_d = IDLE;
          default: state_d = EXT2;
        endcase
      end
      EXT3: begin
        case (ab)
          2'b00: begin
            state_d   = IDLE;
            done_exit = 1'b1;
          end
          2'b11:   state_d = EXT2;
          2'b01:   state_d = WAIT_CLR;
          default: state_d = EXT3;
        endcase
      end
      WAIT_CLR: begin
        if (ab == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign at_cap  = (occ_q.tens == CAP_TENS) && (occ_q.ones == CAP_ONES);
  assign at_zero = (occ_q.tens == 4'd0) && (occ_q.ones == 4'd0);

  // Flags are derived from the next count so they land with the digits.
  always_comb begin
    occ_d    = occ_q;
    entry_d  = 1'b0;
    exit_d   = 1'b0;
    reject_d = 1'b0;
    if (done_entry) begin
      if (at_cap) begin
        reject_d = 1'b1;
      end else begin
        occ_d   = bcd_inc(occ_q);
        entry_d = 1'b1;
      end
    end else if (done_exit) begin
      if (at_zero) begin
        reject_d = 1'b1;
      end else begin
        occ_d  = bcd_dec(occ_q);
        exit_d = 1'b1;
      end
    end
    full_d  = (occ_d.tens == CAP_TENS) && (occ_d.ones == CAP_ONES);
    empty_d = (occ_d.tens == 4'd0) && (occ_d.ones == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      entry_q  <= 1'b0;
      exit_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      entry_q  <= entry_d;
      exit_q   <= exit_d;
      reject_q <= reject_d;
    end
  end

  assign tens_digit   = occ_q.tens;
  assign ones_digit   = occ_q.ones;
  assign full         = full_q;
  assign empty        = empty_q;
  assign entry_pulse  = entry_q;
  assign exit_pulse   = exit_q;
  assign reject_pulse = reject_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Scoreboard bench for parking_occupancy_counter with DEBOUNCE_CYCLES=4, CAPACITY=12.
module tb_parking_occupancy_counter;
  import parking_pkg::*;

  localparam int CAP = 12;
  localparam int EV_ENTRY  = 0;
  localparam int EV_EXIT   = 1;
  localparam int EV_REJECT = 2;

  typedef struct {
    int kind;
    int tens;
    int ones;
    int full;
    int empty;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor_a = 1'b0;
  logic       sensor_b = 1'b0;
  logic [3:0] tens_digit, ones_digit;
  logic       full, empty, entry_pulse, exit_pulse, reject_pulse;

  int  cmp_cnt = 0;
  int  err_cnt = 0;
  int  occ_m   = 0;
  ev_t exp_q[$];

  parking_occupancy_counter #(.CAPACITY(CAP), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor_a     (sensor_a),
    .sensor_b     (sensor_b),
    .tens_digit   (tens_digit),
    .ones_digit   (ones_digit),
    .full         (full),
    .empty        (empty),
    .entry_pulse  (entry_pulse),
    .exit_pulse   (exit_pulse),
    .reject_pulse (reject_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever a strobe appears, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pulse_onehot", (32'(entry_pulse) + 32'(exit_pulse) + 32'(reject_pulse)) <= 1, 1);
      if (entry_pulse || exit_pulse || reject_pulse) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {29'd0, entry_pulse, exit_pulse, reject_pulse}, 0);
        end else begin
          ev_t e;
          int  kind;
          e = exp_q.pop_front();
          kind = entry_pulse ? EV_ENTRY : (exit_pulse ? EV_EXIT : EV_REJECT);
          chk("ev_kind",  kind, e.kind);
          chk("ev_tens",  int'(tens_digit), e.tens);
          chk("ev_ones",  int'(ones_digit), e.ones);
          chk("ev_full",  int'(full), e.full);
          chk("ev_empty", int'(empty), e.empty);
        end
      end
    end
  end

  task automatic push_ev(input int kind);
    ev_t e;
    e.kind  = kind;
    e.tens  = occ_m / 10;
    e.ones  = occ_m % 10;
    e.full  = (occ_m == CAP) ? 1 : 0;
    e.empty = (occ_m == 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic a, input logic b);
    sensor_a = a;
    sensor_b = b;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic do_entry();
    if (occ_m == CAP) push_ev(EV_REJECT);
    else begin
      occ_m++;
      push_ev(EV_ENTRY);
    end
    step(1, 0); step(1, 1); step(0, 1); step(0, 0);
  endtask

  task automatic do_exit();
    if (occ_m == 0) push_ev(EV_REJECT);
    else begin
      occ_m--;
      push_ev(EV_EXIT);
    end
    step(0, 1); step(1, 1); step(1, 0); step(0, 0);
  endtask

  task automatic chk_digits(input string name, input int t, input int o);
    chk({name, "_tens"}, int'(tens_digit), t);
    chk({name, "_ones"}, int'(ones_digit), o);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_digits("rst", 0, 0);
    chk("rst_full", int'(full), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_pulses", int'({entry_pulse, exit_pulse, reject_pulse}), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single entry
    do_entry();
    chk_digits("t1", 0, 1);
    chk("t1_empty", int'(empty), 0);

    // 2: BCD carry and borrow
    while (occ_m < 9) do_entry();
    do_entry();
    chk_digits("t2_carry", 1, 0);
    do_exit();
    chk_digits("t2_borrow", 0, 9);

    // 3: fill, reject at full, drain, reject at empty
    while (occ_m < CAP) do_entry();
    chk("t3_full", int'(full), 1);
    do_entry();
    chk_digits("t3_full_hold", 1, 2);
    while (occ_m > 0) do_exit();
    do_exit();
    chk_digits("t3_empty_hold", 0, 0);
    chk("t3_empty", int'(empty), 1);

    // 4: glitches and an aborted passage
    sensor_a = 1'b1; @(posedge clk); #1; sensor_a = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("t4_glitch1_state", int'(dut.state_q), int'(IDLE));
    sensor_a = 1'b1; repeat (3) @(posedge clk); #1; sensor_a = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("t4_glitch3_state", int'(dut.state_q), int'(IDLE));
    step(1, 0); step(1, 1); step(1, 0); step(0, 0);
    chk_digits("t4_abort", 0, 0);

    // 5: both beams together, then a valid entry
    step(1, 1);
    chk("t5_waitclr", int'(dut.state_q), int'(WAIT_CLR));
    step(0, 0);
    chk("t5_idle", int'(dut.state_q), int'(IDLE));
    do_entry();
    chk_digits("t5_entry", 0, 1);

    // 6: reset in ENT3 at occupancy 5
    while (occ_m < 5) do_entry();
    chk_digits("t6_pre", 0, 5);
    step(1, 0); step(1, 1); step(0, 1);
    chk("t6_in_ent3", int'(dut.state_q), int'(ENT3));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_digits("t6_async", 0, 0);
    chk("t6_async_empty", int'(empty), 1);
    chk("t6_async_full", int'(full), 0);
    chk("t6_async_pulses", int'({entry_pulse, exit_pulse, reject_pulse}), 0);
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    occ_m = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 0);
    step(0, 0);
    chk_digits("t6_after", 0, 0);
    chk("t6_after_state", int'(dut.state_q), int'(IDLE));

    // Drain check
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
